// File: rtl/shiftreg_ctrl.sv
// shiftreg_ctrl: framed full-duplex serial sequencer
// for an external parallel-load shift register.
module shiftreg_ctrl #(
  parameter int   WIDTH      = 8,
  parameter int   DIV_W      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             msb_first,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             abort,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             bit_tick,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             sr_load,
  output logic             sr_ena,
  output logic             sr_dir,
  output logic [WIDTH-1:0] sr_dload,
  output logic             sr_d,
  input  logic             sr_q,
  input  logic [WIDTH-1:0] sr_qpar
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("shiftreg_ctrl: WIDTH must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] per_q;
  logic [CNT_W-1:0] bit_q;
  logic             dir_q;
  logic [WIDTH-1:0] dload_q;
  logic [WIDTH-1:0] rx_q;
  logic             tick;
  logic             accept;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state, bit strobe and handshake decode
  always_comb begin
    state_nx = state;
    tick     = 1'b0;
    accept   = 1'b0;
    tx_ready = 1'b0;
    sr_load  = 1'b0;
    rx_valid = 1'b0;
    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          accept   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        sr_load  = 1'b1;
        state_nx = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (per_q == div_q) begin
          tick = 1'b1;
          if (bit_q == CNT_W'(WIDTH - 1))
            state_nx = DONE;
        end
      end
      DONE: begin
        rx_valid = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // transfer settings, bit/period counters, rx capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dload_q <= '0;
      dir_q   <= 1'b0;
      div_q   <= '0;
      per_q   <= '0;
      bit_q   <= '0;
      rx_q    <= '0;
    end else begin
      if (accept) begin
        dload_q <= tx_data;
        dir_q   <= msb_first;
        div_q   <= clk_div;
      end
      if (state == SHIFT && !abort) begin
        if (tick) begin
          per_q <= '0;
          bit_q <= bit_q + 1'b1;
        end else begin
          per_q <= per_q + 1'b1;
        end
      end else begin
        per_q <= '0;
        bit_q <= '0;
      end
      if (state == DONE)
        rx_q <= sr_qpar;
    end
  end

  assign busy     = (state != IDLE);
  assign sr_ena   = tick;
  assign bit_tick = tick;
  assign sr_d     = ser_in;
  assign sr_dload = dload_q;
  assign sr_dir   = dir_q &
                    ((state == LOAD) ||
                     (state == SHIFT));
  assign ser_out  = (state == SHIFT) ?
                    sr_q : IDLE_LEVEL;
  // word is visible during the rx_valid cycle
  // and held from the capture register after
  assign rx_data  = (state == DONE) ?
                    sr_qpar : rx_q;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// tb_shiftreg_ctrl: directed bench with rx
// scoreboard and a behavioural shift register.
module tb_shiftreg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       msb_first;
  logic [7:0] clk_div;
  logic       abort;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       bit_tick;
  logic       ser_in;
  logic       ser_out;
  logic       sr_load;
  logic       sr_ena;
  logic       sr_dir;
  logic [7:0] sr_dload;
  logic       sr_d;
  logic       sr_q;
  logic [7:0] sr_qpar;

  shiftreg_ctrl #(
    .WIDTH(8),
    .DIV_W(8),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .msb_first(msb_first),
    .clk_div(clk_div),
    .abort(abort),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .busy(busy),
    .bit_tick(bit_tick),
    .ser_in(ser_in),
    .ser_out(ser_out),
    .sr_load(sr_load),
    .sr_ena(sr_ena),
    .sr_dir(sr_dir),
    .sr_dload(sr_dload),
    .sr_d(sr_d),
    .sr_q(sr_q),
    .sr_qpar(sr_qpar)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ena_cnt = 0;
  int         ena_base = 0;
  logic       loop = 1'b1;
  logic [7:0] pat = 8'h00;
  logic [7:0] sr = 8'h00;

  // shift register model
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sr_ena) ena_cnt <= ena_cnt + 1;
    if (sr_load)
      sr <= sr_dload;
    else if (sr_ena)
      sr <= sr_dir ? {sr[6:0], sr_d}
                   : {sr_d, sr[7:1]};
  end

  assign sr_q    = sr_dir ? sr[7] : sr[0];
  assign sr_qpar = sr;

  // serial line: loopback or LSB-first pattern
  always_comb begin
    ser_in = ser_out;
    if (!loop)
      ser_in = pat[3'(ena_cnt - ena_base)];
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               nm, got, exp);
    end
  endtask

  // monitor: pop and compare on each rx_valid
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got=%0h",
                 rx_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rx_data !== e.data ||
            cyc != e.cyc ||
            tx_ready !== 1'b0) begin
          errors++;
          $display({"FAIL rx_word got=%0h @%0d",
                    " rdy=%b exp=%0h @%0d"},
                   rx_data, cyc, tx_ready,
                   e.data, e.cyc);
        end
      end
    end
  end

  // caller is at a negedge with controller idle
  task automatic send(input logic [7:0] d,
                      input logic       m,
                      input logic [7:0] dv,
                      input logic [7:0] x);
    int a;
    exp_t e;
    tx_data   = d;
    msb_first = m;
    clk_div   = dv;
    tx_valid  = 1'b1;
    ena_base  = ena_cnt;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    a = cyc;
    chk("accept_load", 32'(sr_load), 32'd1);
    e.data = x;
    e.cyc  = a + 1 + 8 * (int'(dv) + 1);
    sb.push_back(e);
  endtask

  task automatic wait_rx();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rx_valid !== 1'b1 && n < 400);
    if (rx_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout got=0 exp=1");
    end
  endtask

  initial begin
    int snap;
    logic [7:0] a5;
    rst_n     = 1'b0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    msb_first = 1'b0;
    clk_div   = 8'h00;
    abort     = 1'b0;

    // 1: reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ser_out", 32'(ser_out), 32'd1);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);

    // 2: loopback A5, msb first, div 0
    a5 = 8'hA5;
    loop = 1'b1;
    send(8'hA5, 1'b1, 8'd0, 8'hA5);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s2_ser_out", 32'(ser_out),
          32'(a5[7-k]));
    end
    wait_rx();
    chk("s2_ena_cnt", 32'(ena_cnt - ena_base),
        32'd8);
    @(negedge clk);
    chk("s2_tx_ready", 32'(tx_ready), 32'd1);

    // 3: div 3, lsb first, ser_in = 3C
    loop = 1'b0;
    pat  = 8'h3C;
    send(8'h01, 1'b0, 8'd3, 8'h3C);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("s3_ser_out", 32'(ser_out),
          32'(k < 4));
      chk("s3_sr_ena", 32'(sr_ena),
          32'((k % 4) == 3));
    end
    wait_rx();
    chk("s3_ena_cnt", 32'(ena_cnt - ena_base),
        32'd8);
    @(negedge clk);

    // 4: settings changed mid-transfer
    send(8'h01, 1'b0, 8'd3, 8'h3C);
    repeat (4) @(negedge clk);
    clk_div   = 8'd0;
    msb_first = 1'b1;
    tx_data   = 8'hFF;
    wait_rx();
    chk("s4_ena_cnt", 32'(ena_cnt - ena_base),
        32'd8);
    @(negedge clk);

    // 5: abort in 3rd shift cycle, then resend
    loop = 1'b1;
    tx_data = 8'h81;
    msb_first = 1'b1;
    clk_div = 8'd0;
    tx_valid = 1'b1;
    ena_base = ena_cnt;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    snap  = ena_cnt;
    @(negedge clk);
    abort = 1'b0;
    chk("s5_tx_ready", 32'(tx_ready), 32'd1);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_rx_data", 32'(rx_data), 32'h3C);
    chk("s5_no_ena", 32'(ena_cnt), 32'(snap));
    send(8'h96, 1'b0, 8'd1, 8'h96);
    wait_rx();
    @(negedge clk);

    // 6: reset mid-shift, 5A held across it
    send(8'h33, 1'b1, 8'd2, 8'h33);
    void'(sb.pop_back());
    repeat (4) @(negedge clk);
    tx_data   = 8'h5A;
    msb_first = 1'b1;
    clk_div   = 8'd0;
    tx_valid  = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    chk("s6_tx_ready", 32'(tx_ready), 32'd1);
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_ser_out", 32'(ser_out), 32'd1);
    chk("s6_rx_valid", 32'(rx_valid), 32'd0);
    chk("s6_bit_tick", 32'(bit_tick), 32'd0);
    chk("s6_sr_load", 32'(sr_load), 32'd0);
    chk("s6_sr_ena", 32'(sr_ena), 32'd0);
    chk("s6_sr_dir", 32'(sr_dir), 32'd0);
    chk("s6_sr_dload", 32'(sr_dload), 32'd0);
    chk("s6_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h5A, 1'b1, 8'd0, 8'h5A);
    chk("s6_dload", 32'(sr_dload), 32'h5A);
    chk("s6_dir", 32'(sr_dir), 32'd1);
    wait_rx();
    repeat (3) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
